// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one instruction per step over a req/ack
// handshake and advances the PC by pc + 4 + pc_offset once execution completes.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [25:0] jtr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] pc_offset,
    input  logic        halt,
    output logic        halted,
    output logic        pc_misalign,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        load_instr;
    logic        retire;
    logic [31:0] pc_next_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs depend on the state register only, never on inputs.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        load_instr  = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    retire     = 1'b1;
                    state_next = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc_next_raw = pc + 32'd4 + pc_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_count <= '0;
            pc_misalign <= 1'b0;
        end else begin
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                // Low bits are dropped so the fetch address stays word-aligned.
                pc          <= {pc_next_raw[31:2], 2'b00};
                instr_count <= instr_count + 32'd1;
                if (pc_next_raw[1:0] != 2'b00) begin
                    pc_misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign jtr       = instr[25:0];

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-issue RISC core: holds the program counter, fetches one 32-bit instruction per step from instruction memory over a req/ack handshake, and presents it to decode and the branch unit. Once the instruction completes, it takes the branch unit's `pc_offset` and advances the PC to `pc + 4 + pc_offset`. It also keeps a retired-instruction counter, a sticky misalignment flag and a halt state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  byte address of the fetch; equals `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  instruction register.
- `opcode`  out  6  `instr[31:26]`.
- `jtr`  out  26  `instr[25:0]`.
- `pc`  out  32  address of the instruction held in `instr`.
- `instr_valid`  out  1  `instr`, `opcode` and `jtr` are valid for execution.
- `exec_done`  in  1  the instruction completes this cycle; `pc_offset` is valid.
- `pc_offset`  in  32  branch-unit offset relative to `pc + 4`; two's complement.
- `halt`  in  1  decode requests a stop; sampled only together with `exec_done`.
- `halted`  out  1  core stopped.
- `pc_misalign`  out  1  sticky flag: a computed next PC had bits [1:0] nonzero.
- `instr_count`  out  32  number of retired instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALTED.
- **IDLE**
  - Entered on reset; lasts exactly one cycle, then moves to FETCH.
  - `imem_req` = 0.
- **FETCH**
  - `imem_req` = 1 and `imem_addr` = `pc`, both held stable until `imem_ack`.
  - On a clock edge with `imem_ack` = 1: `instr` <= `imem_rdata`, state moves to EXEC.
- **EXEC**
  - `instr_valid` = 1.
  - The block waits in EXEC for any number of cycles until `exec_done` = 1.
  - On a clock edge with `exec_done` = 1:
    - `pc` <= next PC.
    - `instr_count` <= `instr_count` + 1.
    - State moves to FETCH, or to HALTED if `halt` = 1.
  - `halt` without `exec_done` is ignored.
- **HALTED**
  - Terminal state; only `rst` leaves it.
  - `halted` = 1, `imem_req` = 0, `instr_valid` = 0.
  - `pc` and `instr` hold their values.
- **Next-PC arithmetic**
  - next = `pc` + 32'd4 + `pc_offset`, modulo 2^32.
  - Wrap-around is silent: 32'hFFFF_FFFC + 4 + 0 gives 0.
  - If next[1:0] != 0: `pc` is loaded with {next[31:2], 2'b00} and `pc_misalign` is set.
  - `pc_misalign` clears only on reset.
- **Output decoding**
  - `instr_count` wraps from 32'hFFFF_FFFF to 0.
  - `opcode`/`jtr` are a pure slice of `instr`.
  - `imem_req`, `instr_valid` and `halted` are decoded from the state register only; they never depend combinationally on any input.
- **Ignored inputs**
  - `imem_ack` outside FETCH.
  - `exec_done` outside EXEC.

## Timing
- **Reset values** (applied immediately on `rst`, independent of `clk`):
  - `pc` = `RESET_PC`, `instr` = 0, `instr_count` = 0, `pc_misalign` = 0.
  - State = IDLE, so `imem_req` = 0, `instr_valid` = 0, `halted` = 0.
- **After reset release**
  - First rising edge: IDLE -> FETCH.
  - `imem_req` rises after that edge.
- **Zero-wait memory** (`imem_ack` asserted in the first FETCH cycle): FETCH lasts 1 cycle.
  - `instr_valid` rises at the next edge.
- **Minimum throughput**: 2 cycles per instruction (1 FETCH + 1 EXEC).
  - Each memory wait cycle adds 1.
  - Each cycle without `exec_done` in EXEC adds 1.
- **PC update**
  - New `pc` is visible the cycle after the `exec_done` edge.
  - That same cycle is the first FETCH cycle, with `imem_addr` = new `pc`.
- **Reset mid-operation**: asserting `rst` in any state aborts immediately.
  - `imem_req` drops asynchronously.
  - A pending `imem_ack` is discarded.

## Test plan
- **Reset and first fetch**
  - Stimulus: `RESET_PC`=32'h100; release `rst`; `imem_ack` tied high, `imem_rdata`=32'h1400_0003.
  - Required: cycle 1 IDLE with `imem_req`=0; cycle 2 `imem_req`=1 and `imem_addr`=32'h100; cycle 3 `instr_valid`=1, `opcode`=6'h05, `jtr`=26'h3.
- **Sequential advance**
  - Stimulus: from `pc`=32'h100, `exec_done`=1 with `pc_offset`=0, repeated three times.
  - Required: `pc` goes 32'h104, 32'h108, 32'h10C; `instr_count`=3.
- **Branch and wait states**
  - Stimulus: `pc_offset`=32'hFFFF_FFF0 at `pc`=32'h40; memory delays `imem_ack` by 3 cycles.
  - Required: `pc`=32'h34; `imem_req` and `imem_addr` held for 4 cycles; `instr` updates only on the ack edge.
- **Wrap and misalign**
  - Stimulus: `pc`=32'hFFFF_FFFC with `pc_offset`=0, then `pc_offset`=32'h2.
  - Required: `pc` becomes 0, then 32'h4 with `pc_misalign`=1; the flag stays 1 until reset.
- **Halt**
  - Stimulus: `exec_done`=1 together with `halt`=1.
  - Required: `pc` updates; `halted`=1 from the next cycle; `imem_req`=0 indefinitely; a later `exec_done` has no effect.
- **Async reset mid-fetch**
  - Stimulus: assert `rst` between clock edges while in FETCH.
  - Required: `imem_req` drops to 0 before the next edge; `pc`=`RESET_PC`; `instr_count`=0.
